// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the EX-stage branch resolution logic:
// funct3 branch encodings, the resolve FSM state type and the base XLEN.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } bru_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational taken/not-taken decision for RV32 control flow, built from
// the comparator flags. Jumps are unconditionally taken.
module branch_cond_eval
  import rv32_pkg::*;
(
  input  logic       is_jal,
  input  logic       is_jalr,
  input  logic [2:0] funct3,
  input  logic       neq,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       is_cond
);

  assign is_cond = !(is_jal || is_jalr);

  always_comb begin
    taken = 1'b0;
    if (!is_cond) begin
      taken = 1'b1;
    end else begin
      // funct3 010/011 are not branch encodings and resolve not-taken
      case (funct3)
        F3_BEQ:  taken = !neq;
        F3_BNE:  taken = neq;
        F3_BLT:  taken = lt;
        F3_BGE:  taken = !lt;
        F3_BLTU: taken = ltu;
        F3_BGEU: taken = !ltu;
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: taken decision, target generation, a held
// redirect offer to IF, a timed IF/ID flush and wrap-around statistics.
module branch_resolve_unit
  import rv32_pkg::*;
#(
  parameter int XLEN         = rv32_pkg::XLEN,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid_i,
  output logic             br_ready_o,
  input  logic             is_jal_i,
  input  logic             is_jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic             neq_i,
  input  logic             b_is_zero_i,
  input  logic             lt_i,
  input  logic             ltu_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic             redirect_valid_o,
  input  logic             redirect_ready_i,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [XLEN-1:0]  link_pc_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] taken_count_o,
  output logic [CNT_W-1:0] zero_cmp_count_o,
  output bru_state_e       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Once raised, redirect_valid_o and redirect_pc_o stay stable
  // until redirect_ready_i; EX must hold br_valid_i and its operands until
  // br_ready_o.

  bru_state_e      state;
  bru_state_e      state_next;
  logic [3:0]      flush_cnt;
  logic            accept;
  logic            taken;
  logic            is_cond;
  logic            aligned;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  branch_cond_eval u_cond (
    .is_jal  (is_jal_i),
    .is_jalr (is_jalr_i),
    .funct3  (funct3_i),
    .neq     (neq_i),
    .lt      (lt_i),
    .ltu     (ltu_i),
    .taken   (taken),
    .is_cond (is_cond)
  );

  assign accept    = br_valid_i && br_ready_o;
  assign jalr_sum  = rs1_i + imm_i;
  // JALR takes priority over JAL when both flags are set
  assign target    = is_jalr_i ? (jalr_sum & ~XLEN'(1)) : (pc_i + imm_i);
  assign aligned   = (target[1:0] == 2'b00);
  assign link_pc_o = pc_i + XLEN'(4);

  assign dbg_state_o = state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept && taken && aligned) state_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready_i) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt <= 4'd1) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    br_ready_o       = 1'b0;
    redirect_valid_o = 1'b0;
    flush_o          = 1'b0;
    case (state)
      ST_IDLE:     br_ready_o       = 1'b1;
      ST_REDIRECT: redirect_valid_o = 1'b1;
      ST_FLUSH:    flush_o          = 1'b1;
      default:     br_ready_o       = 1'b0;
    endcase
  end

  // Redirect target, flush timer and misalign pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_o <= '0;
      flush_cnt     <= '0;
      misalign_o    <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && taken) begin
            if (aligned) redirect_pc_o <= target;
            else         misalign_o    <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready_i) flush_cnt <= 4'(FLUSH_CYCLES);
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt - 4'd1;
        end
        default: flush_cnt <= '0;
      endcase
    end
  end

  // Statistics; misaligned jumps still count as taken
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_o       <= '0;
      taken_count_o    <= '0;
      zero_cmp_count_o <= '0;
    end else if (accept) begin
      br_count_o <= br_count_o + CNT_W'(1);
      if (taken) taken_count_o <= taken_count_o + CNT_W'(1);
      if (is_cond && b_is_zero_i) zero_cmp_count_o <= zero_cmp_count_o + CNT_W'(1);
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
EX-stage consumer of the branch_comparator flags (neq, B_is_zero, lt) plus an unsigned less-than flag. It decides taken/not-taken for RV32 conditional branches, JAL and JALR, and computes the target. It drives a held redirect handshake to IF and a timed flush of younger IF/ID instructions. It also keeps wrap-around branch/taken statistics counters.

Parameters:
XLEN, 32, datapath and PC width
FLUSH_CYCLES, 2, cycles flush_o is asserted after a redirect is accepted (1..15)
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
br_valid_i  in  1  EX holds a control-flow instruction
br_ready_o  out  1  unit can accept br_valid_i this cycle
is_jal_i  in  1  instruction is JAL
is_jalr_i  in  1  instruction is JALR
funct3_i  in  3  branch funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
neq_i  in  1  from comparator: A != B
b_is_zero_i  in  1  from comparator: B == 0 (statistics only)
lt_i  in  1  from comparator: signed A < B
ltu_i  in  1  unsigned A < B
pc_i  in  XLEN  PC of the instruction
rs1_i  in  XLEN  rs1 value (JALR base)
imm_i  in  XLEN  sign-extended immediate
redirect_valid_o  out  1  new PC offered to IF
redirect_ready_i  in  1  IF accepts redirect
redirect_pc_o  out  XLEN  redirect target
link_pc_o  out  XLEN  pc_i+4, combinational, for rd writeback
flush_o  out  1  squash IF/ID contents
misalign_o  out  1  one-cycle pulse: taken target not 4-byte aligned
br_count_o  out  CNT_W  accepted control-flow instructions
taken_count_o  out  CNT_W  accepted instructions resolved taken
zero_cmp_count_o  out  CNT_W  accepted conditional branches with b_is_zero_i=1

Behaviour:
- Reset: state IDLE; redirect_valid_o=0; redirect_pc_o=0; flush_o=0; misalign_o=0; all counters 0; br_ready_o=1.
- Accept = br_valid_i && br_ready_o. br_ready_o=1 only in IDLE.
- Taken decision (combinational at accept): JAL and JALR are always taken. Otherwise use funct3:
  - BEQ !neq; BNE neq; BLT lt; BGE !lt; BLTU ltu; BGEU !ltu.
  - funct3 010/011 is not taken.
  - If is_jal_i and is_jalr_i are both set, JALR wins.
- Target: JALR uses (rs1_i+imm_i) with bit0 cleared. All others use pc_i+imm_i. Addition is modulo 2^XLEN (wraps).
- States:
  - IDLE: on accept and taken with target[1:0]==00, latch target into redirect_pc_o, set redirect_valid_o, and go to REDIRECT. On accept and taken with misaligned target, pulse misalign_o next cycle, issue no redirect, stay IDLE. On not-taken, stay IDLE.
  - REDIRECT: hold redirect_valid_o and redirect_pc_o stable until redirect_ready_i. Accepted the same cycle the valid first appears if ready is already high. On acceptance, clear valid, assert flush_o, load the flush counter with FLUSH_CYCLES, and go to FLUSH.
  - FLUSH: flush_o=1. Decrement the counter each cycle; at zero, deassert flush_o and return to IDLE. flush_o is high exactly FLUSH_CYCLES cycles.
- Latency: the redirect is valid the cycle after accept. The minimum accept-to-next-accept time for a taken branch is 2+FLUSH_CYCLES cycles. Not-taken branches may be accepted back-to-back.
- Counters, updated on accept:
  - br_count +1.
  - taken_count +1 if taken, including misaligned.
  - zero_cmp_count +1 if conditional and b_is_zero_i.
  - All counters wrap at 2^CNT_W.
- rst mid-operation (REDIRECT or FLUSH): everything returns to reset values next edge and the pending redirect is dropped. rst has priority over all inputs.
- br_valid_i while not ready: ignored; EX must hold it. No counters change.

Decomposition:
- Shared package (rv32_pkg): funct3 branch encodings, FSM state enum (IDLE/REDIRECT/FLUSH), XLEN constant.
- Sub-module branch_cond_eval: combinational taken decision from funct3/jal/jalr and the comparator flags. Reusable by a future predictor check.

Test Plan:
- BEQ, neq=0, pc=0x100, imm=0x20, redirect_ready=1 → redirect_pc=0x120 valid one cycle; flush_o high 2 cycles; br_count=1, taken_count=1.
- BGE signed with lt=1 (A=-1, B=1), then BGEU with ltu=0 → first not taken (no redirect, ready stays 1); second taken; taken_count=1.
- JALR rs1=0x1003, imm=0x4 → target 0x1006, misalign_o pulses, no redirect; link_pc=pc+4; taken_count increments.
- Taken BNE with redirect_ready=0 for 3 cycles → redirect_valid_o and redirect_pc_o held stable, br_ready_o=0; new br_valid_i ignored and not counted; flush starts the cycle after ready.
- rst asserted during FLUSH → next cycle flush_o=0, counters 0, br_ready_o=1.
- pc=0xFFFF_FFFC, imm=8, BEQ taken → redirect_pc=0x0000_0004 (wrap). Preset counters near max → wrap to 0.
